// File: rtl/stats_pkg.sv
// Shared statistics-path definitions: default field widths used by the
// collectors, the arbiter and the counter block, plus the beat record type.
package stats_pkg;

   localparam int STATS_INC_WIDTH = 16;
   localparam int STATS_ID_WIDTH  = 8;

   // One statistics beat at the default widths.
   typedef struct packed {
      logic [STATS_INC_WIDTH-1:0] tdata;
      logic [STATS_ID_WIDTH-1:0]  tid;
   } stat_beat_t;

   // Index width for a set of ports; never narrower than one bit.
   function automatic int ptr_width(input int ports);
      return (ports > 1) ? $clog2(ports) : 1;
   endfunction

endpackage

// File: rtl/stats_rr_pick.sv
// Rotating priority encoder: returns the first requesting index found when
// scanning upward from i_ptr, wrapping modulo PORTS. Purely combinational.
module stats_rr_pick
   import stats_pkg::*;
#(
   parameter int PORTS    = 4,
   parameter int CL_PORTS = ptr_width(PORTS)
) (
   input  logic [PORTS-1:0]    i_req,
   input  logic [CL_PORTS-1:0] i_ptr,
   output logic [CL_PORTS-1:0] o_winner,
   output logic                o_any_valid
);

   logic [31:0] w_idx;

   // Scan offsets from farthest to nearest so the nearest requester wins.
   always_comb begin
      o_winner    = '0;
      o_any_valid = |i_req;
      w_idx       = '0;
      for (int i = PORTS - 1; i >= 0; i--) begin
         w_idx = 32'(i_ptr) + 32'(i);
         if (w_idx >= 32'(PORTS)) begin
            w_idx = w_idx - 32'(PORTS);
         end
         if (i_req[w_idx[CL_PORTS-1:0]]) begin
            o_winner = w_idx[CL_PORTS-1:0];
         end
      end
   end

endmodule

// File: rtl/stats_arb.sv
// Round-robin merge of PORTS statistics increment streams into one registered
// stream feeding the shared counter RAM. tid/tdata pass through unmodified.
// Optional build macro STATS_ARB_COALESCE_EN: while the output beat is stalled,
// a winner with the same tid is summed into it if the sum does not carry out.
//
// Handshakes: a beat moves when tvalid && tready on the same rising edge.
// Sources never drop tvalid before acceptance; s_axis_stat_tready is driven
// only to the current winner and only when the output register can take (or
// merge) its beat, so re-arbitration while stalled never loses data.
module stats_arb
   import stats_pkg::*;
#(
   parameter int PORTS          = 4,
   parameter int STAT_INC_WIDTH = STATS_INC_WIDTH,
   parameter int STAT_ID_WIDTH  = STATS_ID_WIDTH,
   parameter int CL_PORTS       = ptr_width(PORTS)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [PORTS*STAT_INC_WIDTH-1:0] s_axis_stat_tdata,
   input  logic [PORTS*STAT_ID_WIDTH-1:0]  s_axis_stat_tid,
   input  logic [PORTS-1:0]            s_axis_stat_tvalid,
   output logic [PORTS-1:0]            s_axis_stat_tready,
   output logic [STAT_INC_WIDTH-1:0]   m_axis_stat_tdata,
   output logic [STAT_ID_WIDTH-1:0]    m_axis_stat_tid,
   output logic                        m_axis_stat_tvalid,
   input  logic                        m_axis_stat_tready,
   output logic [31:0]                 grant_count
);

   logic [STAT_INC_WIDTH-1:0] r_tdata;
   logic [STAT_ID_WIDTH-1:0]  r_tid;
   logic                      r_tvalid;
   logic [CL_PORTS-1:0]       r_ptr;
   logic [31:0]               r_grant_count;

   logic [CL_PORTS-1:0]       w_winner;
   logic [CL_PORTS-1:0]       w_ptr_next;
   logic                      w_any_valid;
   logic                      w_load_ok;
   logic                      w_coal_ok;
   logic                      w_accept;
   logic [STAT_INC_WIDTH-1:0] w_win_tdata;
   logic [STAT_ID_WIDTH-1:0]  w_win_tid;

   stats_rr_pick #(
      .PORTS    (PORTS),
      .CL_PORTS (CL_PORTS)
   ) u_pick (
      .i_req       (s_axis_stat_tvalid),
      .i_ptr       (r_ptr),
      .o_winner    (w_winner),
      .o_any_valid (w_any_valid)
   );

   // Output register can take a new beat when empty or draining this cycle.
   assign w_load_ok = !r_tvalid || m_axis_stat_tready;

`ifdef STATS_ARB_COALESCE_EN
   logic [STAT_INC_WIDTH:0] w_sum;
   assign w_sum     = {1'b0, r_tdata} + {1'b0, w_win_tdata};
   assign w_coal_ok = r_tvalid && !m_axis_stat_tready &&
                      (w_win_tid == r_tid) && !w_sum[STAT_INC_WIDTH];
`else
   assign w_coal_ok = 1'b0;
`endif

   assign w_accept   = !rst && w_any_valid && (w_load_ok || w_coal_ok);
   assign w_ptr_next = (w_winner == CL_PORTS'(PORTS - 1)) ? '0
                                                         : w_winner + CL_PORTS'(1);

   // Select the winner's fields and raise tready only on the winning port.
   always_comb begin
      w_win_tdata        = '0;
      w_win_tid          = '0;
      s_axis_stat_tready = '0;
      for (int p = 0; p < PORTS; p++) begin
         if (w_winner == CL_PORTS'(p)) begin
            w_win_tdata           = s_axis_stat_tdata[p*STAT_INC_WIDTH +: STAT_INC_WIDTH];
            w_win_tid             = s_axis_stat_tid[p*STAT_ID_WIDTH +: STAT_ID_WIDTH];
            s_axis_stat_tready[p] = w_accept;
         end
      end
   end

   // Output beat, rotation pointer and grant counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tdata       <= '0;
         r_tid         <= '0;
         r_tvalid      <= 1'b0;
         r_ptr         <= '0;
         r_grant_count <= '0;
      end else if (w_accept) begin
         if (w_load_ok) begin
            r_tdata <= w_win_tdata;
            r_tid   <= w_win_tid;
         end
`ifdef STATS_ARB_COALESCE_EN
         else begin
            r_tdata <= w_sum[STAT_INC_WIDTH-1:0];
         end
`endif
         r_tvalid      <= 1'b1;
         r_ptr         <= w_ptr_next;
         r_grant_count <= r_grant_count + 32'd1;
      end else if (m_axis_stat_tready) begin
         r_tvalid <= 1'b0;
      end
   end

   assign m_axis_stat_tdata  = r_tdata;
   assign m_axis_stat_tid    = r_tid;
   assign m_axis_stat_tvalid = r_tvalid;
   assign grant_count        = r_grant_count;

endmodule

// File: tb/tb_stats_arb.sv
// Bench for stats_arb: reset, table-driven rotation/stall vectors, coalesce
// and reset-mid-stream sequences, then random traffic against a per-port
// queue model with a starvation bound.
module tb_stats_arb;
   import stats_pkg::*;

   localparam int P  = 4;
   localparam int W  = 16;
   localparam int IW = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [W-1:0]    td   [P];
   logic [IW-1:0]   tidv [P];
   logic [P-1:0]    vld;
   logic            mrdy;
   logic [P*W-1:0]  s_tdata;
   logic [P*IW-1:0] s_tid;
   logic [P-1:0]    s_tready;
   logic [W-1:0]    m_tdata;
   logic [IW-1:0]   m_tid;
   logic            m_tvalid;
   logic [31:0]     gc;

   always_comb begin
      s_tdata = '0;
      s_tid   = '0;
      for (int p = 0; p < P; p++) begin
         s_tdata[p*W +: W]   = td[p];
         s_tid[p*IW +: IW]   = tidv[p];
      end
   end

   stats_arb #(.PORTS(P), .STAT_INC_WIDTH(W), .STAT_ID_WIDTH(IW)) dut (
      .clk                (clk),
      .rst                (rst),
      .s_axis_stat_tdata  (s_tdata),
      .s_axis_stat_tid    (s_tid),
      .s_axis_stat_tvalid (vld),
      .s_axis_stat_tready (s_tready),
      .m_axis_stat_tdata  (m_tdata),
      .m_axis_stat_tid    (m_tid),
      .m_axis_stat_tvalid (m_tvalid),
      .m_axis_stat_tready (mrdy),
      .grant_count        (gc)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_const();
      for (int p = 0; p < P; p++) begin
         td[p]   = W'(p + 3);
         tidv[p] = IW'(8'h10 + p);
      end
   endtask

   // Reset with all ports requesting; tready must stay low throughout.
   task automatic do_reset();
      rst  = 1'b1;
      vld  = '1;
      mrdy = 1'b0;
      #1;
      chk("rst_tready", s_tready, 0);
      tick();
      chk("rst_tready2", s_tready, 0);
      chk("rst_tvalid", m_tvalid, 0);
      chk("rst_tdata", m_tdata, 0);
      chk("rst_tid", m_tid, 0);
      chk("rst_gc", gc, 0);
      tick();
      rst = 1'b0;
      vld = '0;
   endtask

   typedef struct packed {
      logic [3:0]  vld;
      logic        mrdy;
      logic [3:0]  trdy;
      logic        mvalid;
      logic [7:0]  mtid;
      logic [31:0] gc;
   } vec_t;

   vec_t tbl[15];

   // Random-phase model state
   logic [23:0] exp_q[P][$];
   logic [5:0]  seq[P];
   int          wait_c[P];
   int          total_grants;

   // One random cycle: drive, then check output beats and grants against the model.
   task automatic rnd_cycle(input bit allow_new);
      logic [P-1:0] acc;
      int n;
      int g;
      int port;
      stat_beat_t b;
      for (int p = 0; p < P; p++) begin
         if (allow_new && !vld[p] && $urandom_range(0, 99) < 40) begin
            vld[p]  = 1'b1;
            tidv[p] = {2'(p), seq[p]};
            seq[p]  = seq[p] + 6'd1;
            td[p]   = W'($urandom);
         end
      end
      mrdy = allow_new ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      if (m_tvalid && mrdy) begin
         port = int'(m_tid[7:6]);
         if (exp_q[port].size() == 0) begin
            chk("rnd_spurious_beat", {m_tdata, m_tid}, 0);
         end else begin
            chk("rnd_beat", {m_tdata, m_tid}, exp_q[port].pop_front());
         end
      end
      chk("rnd_tready_idle", s_tready & ~vld, 0);
      acc = vld & s_tready;
      n = 0;
      g = 0;
      for (int p = 0; p < P; p++) begin
         if (acc[p]) begin
            n++;
            g = p;
            b.tdata = td[p];
            b.tid   = tidv[p];
            exp_q[p].push_back(b);
         end
      end
      chk("rnd_grants_le1", (n > 1), 0);
      if (n == 1) begin
         total_grants++;
         for (int q = 0; q < P; q++) begin
            if (q == g) begin
               wait_c[q] = 0;
            end else if (vld[q]) begin
               wait_c[q]++;
               chk("rnd_starve", (wait_c[q] > P - 1), 0);
            end
         end
      end
      tick();
      vld = vld & ~acc;
   endtask

   initial begin
      rst  = 1'b1;
      vld  = '0;
      mrdy = 1'b0;
      set_const();
      tick();
      do_reset();

      // Table: single port, full rotation, stalls and drains (ptr starts at 0).
      tbl[0]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 8'h12, 32'd1};
      tbl[1]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 32'd1};
      tbl[2]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 8'h13, 32'd2};
      tbl[3]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 8'h10, 32'd3};
      tbl[4]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 8'h11, 32'd4};
      tbl[5]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 8'h12, 32'd5};
      tbl[6]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 8'h12, 32'd5};
      tbl[7]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 8'h12, 32'd5};
      tbl[8]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 8'h13, 32'd6};
      tbl[9]  = '{4'b0111, 1'b1, 4'b0001, 1'b1, 8'h10, 32'd7};
      tbl[10] = '{4'b0110, 1'b0, 4'b0000, 1'b1, 8'h10, 32'd7};
      tbl[11] = '{4'b0110, 1'b1, 4'b0010, 1'b1, 8'h11, 32'd8};
      tbl[12] = '{4'b0100, 1'b0, 4'b0000, 1'b1, 8'h11, 32'd8};
      tbl[13] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 8'h12, 32'd9};
      tbl[14] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 32'd9};

      set_const();
      for (int i = 0; i < 15; i++) begin
         vld  = tbl[i].vld;
         mrdy = tbl[i].mrdy;
         #1;
         chk($sformatf("tbl%0d_tready", i), s_tready, tbl[i].trdy);
         tick();
         chk($sformatf("tbl%0d_tvalid", i), m_tvalid, tbl[i].mvalid);
         if (tbl[i].mvalid) begin
            chk($sformatf("tbl%0d_tid", i), m_tid, tbl[i].mtid);
            chk($sformatf("tbl%0d_tdata", i), m_tdata, W'(tbl[i].mtid - 8'h10 + 8'd3));
         end
         chk($sformatf("tbl%0d_gc", i), gc, tbl[i].gc);
      end

      // Coalesce corner: held tid 7 / 0xFFF0, then +0x0F, then +1 (carry).
      do_reset();
      td[0] = 16'hFFF0; tidv[0] = 8'h07;
      td[1] = 16'h000F; tidv[1] = 8'h07;
      td[2] = 16'h0001; tidv[2] = 8'h07;
      vld = 4'b0001; mrdy = 1'b0;
      #1;
      chk("coal_first_tready", s_tready, 4'b0001);
      tick();
      chk("coal_first_data", m_tdata, 16'hFFF0);
      chk("coal_first_gc", gc, 1);
      vld = 4'b0010;
      #1;
`ifdef STATS_ARB_COALESCE_EN
      chk("coal_merge_tready", s_tready, 4'b0010);
      tick();
      chk("coal_merge_data", m_tdata, 16'hFFFF);
      chk("coal_merge_gc", gc, 2);
      vld = 4'b0100;
`else
      chk("coal_merge_tready", s_tready, 4'b0000);
      tick();
      chk("coal_merge_data", m_tdata, 16'hFFF0);
      chk("coal_merge_gc", gc, 1);
      vld = 4'b0110;
`endif
      #1;
      chk("coal_carry_tready", s_tready, 4'b0000);
      tick();
      chk("coal_carry_tvalid", m_tvalid, 1);
`ifdef STATS_ARB_COALESCE_EN
      chk("coal_carry_data", m_tdata, 16'hFFFF);
      mrdy = 1'b1;
      #1;
      chk("coal_drain_tready", s_tready, 4'b0100);
      tick();
      chk("coal_drain_data", m_tdata, 16'h0001);
`else
      chk("coal_carry_data", m_tdata, 16'hFFF0);
      mrdy = 1'b1;
      #1;
      chk("coal_drain_tready", s_tready, 4'b0010);
      tick();
      chk("coal_drain_data", m_tdata, 16'h000F);
`endif

      // Reset mid-stream: output beat pending, ports valid; rotation restarts at 0.
      mrdy = 1'b0;
      vld  = 4'b1111;
      do_reset();
      set_const();
      vld  = 4'b1111;
      mrdy = 1'b1;
      #1;
      chk("post_rst_tready", s_tready, 4'b0001);
      tick();
      chk("post_rst_tid", m_tid, 8'h10);
      chk("post_rst_gc", gc, 1);

      // Random traffic against the per-port queue model.
      do_reset();
      for (int p = 0; p < P; p++) begin
         seq[p]    = '0;
         wait_c[p] = 0;
         exp_q[p].delete();
      end
      total_grants = 0;
      for (int c = 0; c < 2000; c++) begin
         rnd_cycle(1'b1);
      end
      for (int c = 0; c < 200; c++) begin
         if (vld == '0 && !m_tvalid) break;
         rnd_cycle(1'b0);
      end
      chk("drain_done", (vld != '0) || m_tvalid, 0);
      for (int p = 0; p < P; p++) begin
         chk($sformatf("drain_q%0d_empty", p), exp_q[p].size(), 0);
      end
      chk("rnd_gc", gc, total_grants);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
